// File: rtl/data_mem_responder.sv
// Memory-side responder for the LDR/STR path: latches a request, waits WAIT_CYCLES,
// then performs a word access on a RAM and pulses Ready with read data or an address error.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic [31:0] AddressBus,
    input  logic        RW,
    input  logic [31:0] Dout,
    output logic [31:0] Din,
    output logic        Ready,
    output logic        Busy,
    output logic        AddrErr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_data;
    logic               lat_rw;
    logic [31:0]        mem [DEPTH];

    logic [29:0]        word_idx;
    logic [IDX_W-1:0]   ram_idx;
    logic               addr_bad;

    // Decode is taken only from the latched request, never the live bus.
    always_comb begin
        word_idx = lat_addr[31:2];
        ram_idx  = word_idx[IDX_W-1:0];
        addr_bad = (lat_addr[1:0] != 2'b00) || ({2'b00, word_idx} >= DEPTH);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
            Din      <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            AddrErr  <= 1'b0;
            mem      <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    Ready <= 1'b0;
                    if (Req) begin
                        lat_addr <= AddressBus;
                        lat_data <= Dout;
                        lat_rw   <= RW;
                        Busy     <= 1'b1;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    // Leaving on a count of 1 lands RESP exactly WAIT_CYCLES edges after acceptance.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    Ready   <= 1'b1;
                    Busy    <= 1'b0;
                    AddrErr <= addr_bad;
                    state   <= IDLE;
                    if (addr_bad) begin
                        Din <= '0;
                    end else if (lat_rw) begin
                        Din <= mem[ram_idx];
                    end else begin
                        mem[ram_idx] <= lat_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
